// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: holds the PC, reads one word from synchronous
// instruction memory per request and presents it to the decoder.
module instr_fetch_unit #(
   parameter int          ADDR_W   = 16,
   parameter int          MEM_LAT  = 1,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_en,
   input  logic              pc_load,
   input  logic [31:0]       pc_next,
   output logic              imem_en,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_dout,
   output logic [31:0]       instr,
   output logic [31:0]       pc,
   output logic [31:0]       pc_plus4,
   output logic              fetch_done,
   output logic              busy,
   output logic              misaligned
);

   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             state_q, state_nxt;
   logic [31:0]        pc_q;
   logic [31:0]        instr_q;
   logic               pending_q;
   logic               mis_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               aligned;

   assign aligned   = (pc_q[1:0] == 2'b00);
   assign pc        = pc_q;
   assign pc_plus4  = pc_q + 32'd4;
   assign imem_addr = pc_q[ADDR_W+1:2];
   assign instr     = instr_q;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values; combinational blocks below use blocking (=).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // NOTE: state_nxt is defaulted first so no path through the case infers a latch.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_IDLE: begin
            // A redirect arriving with the request defers the issue by one
            // cycle via pending, so the fetch uses the new PC.
            if (pending_q || (fetch_en && !pc_load)) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            if (pc_load)       state_nxt = S_IDLE;
            else if (!aligned) state_nxt = S_DONE;
            else               state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (pc_load)                state_nxt = S_IDLE;
            else if (cnt_q == '0)       state_nxt = S_DONE;
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      imem_en    = 1'b0;
      fetch_done = 1'b0;
      busy       = 1'b1;
      misaligned = 1'b0;
      case (state_q)
         S_IDLE:  busy = 1'b0;
         S_ISSUE: imem_en = aligned;
         S_WAIT:  ;
         S_DONE: begin
            fetch_done = 1'b1;
            misaligned = mis_q;
         end
         default: busy = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= RESET_PC;
         instr_q   <= 32'h0;
         pending_q <= 1'b0;
         mis_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         if (pc_load)                pc_q <= pc_next;
         else if (state_q == S_DONE) pc_q <= pc_plus4;

         if (state_q == S_IDLE) pending_q <= fetch_en && pc_load && !pending_q;

         if (state_q == S_ISSUE) begin
            cnt_q <= CNT_W'(MEM_LAT - 1);
            mis_q <= !aligned;
            if (!pc_load && !aligned) instr_q <= 32'h0;
         end

         if (state_q == S_WAIT) begin
            if (cnt_q != '0)   cnt_q   <= cnt_q - 1'b1;
            else if (!pc_load) instr_q <= imem_dout;
         end
      end
   end

endmodule
